// File: rtl/mem_bus_pkg.sv
// Shared data-bus definitions: bridge FSM states, request record and fault causes.
package mem_bus_pkg;

  typedef logic [2:0] dmem_state_t;

  localparam dmem_state_t ST_IDLE    = 3'd0;
  localparam dmem_state_t ST_WAIT    = 3'd1;
  localparam dmem_state_t ST_ISSUE   = 3'd2;
  localparam dmem_state_t ST_CAPTURE = 3'd3;
  localparam dmem_state_t ST_RESP    = 3'd4;
  localparam dmem_state_t ST_FAULT   = 3'd5;

  localparam logic [1:0] DMEM_FAULT_NONE     = 2'd0;
  localparam logic [1:0] DMEM_FAULT_MISALIGN = 2'd1;
  localparam logic [1:0] DMEM_FAULT_RANGE    = 2'd2;
  localparam logic [1:0] DMEM_FAULT_BOTH     = 2'd3;

  typedef struct packed {
    logic [29:0] waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        is_wr;
  } dmem_req_t;

  // Conflicting strobes win over address problems so the request is answered as a write.
  function automatic logic [1:0] dmem_fault_cause(input logic [31:0] addr, input logic rd,
                                                  input logic wr, input int unsigned words);
    if (rd && wr) return DMEM_FAULT_BOTH;
    if (addr[1:0] != 2'b00) return DMEM_FAULT_MISALIGN;
    if ({2'b00, addr[31:2]} >= words) return DMEM_FAULT_RANGE;
    return DMEM_FAULT_NONE;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// 4-bit wait-state down-counter; saturates at zero instead of wrapping.
module wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);
  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_cnt <= 4'd0;
    else if (i_load)                  r_cnt <= i_load_val;
    else if (i_dec && r_cnt != 4'd0)  r_cnt <= r_cnt - 4'd1;
  end

  assign o_zero = (r_cnt == 4'd0);
endmodule

// File: rtl/dmem_bridge.sv
// CPU data port to single-cycle-read ssram bridge with wait states and fault reporting.
module dmem_bridge
  import mem_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read_enable,
  input  logic        cpu_write_enable,
  input  logic [3:0]  cpu_byte_enable,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        cpu_read_rdy,
  output logic        cpu_write_rdy,
  output logic        cpu_fault,
  output logic [31:0] mem_address,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  localparam bit         LP_HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [3:0] LP_WS_LOAD  = LP_HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t r_state, w_next;
  dmem_req_t   r_req;
  logic [31:0] r_rdata;
  logic        w_req, w_fault, w_accept, w_cnt_load, w_cnt_dec, w_cnt_zero, w_done;

  assign w_req      = cpu_read_enable | cpu_write_enable;
  assign w_fault    = dmem_fault_cause(cpu_address, cpu_read_enable, cpu_write_enable,
                                       ADDR_WORDS) != DMEM_FAULT_NONE;
  assign w_accept   = (r_state == ST_IDLE) && w_req;
  assign w_cnt_load = w_accept && !w_fault && LP_HAS_WAIT;
  assign w_cnt_dec  = (r_state == ST_WAIT);

  wait_counter u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (LP_WS_LOAD),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_req) w_next = w_fault ? ST_FAULT : (LP_HAS_WAIT ? ST_WAIT : ST_ISSUE);
      ST_WAIT:    if (w_cnt_zero) w_next = ST_ISSUE;
      ST_ISSUE:   w_next = r_req.is_wr ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: w_next = ST_RESP;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_req.waddr <= cpu_address[31:2];
        r_req.be    <= cpu_byte_enable;
        r_req.wdata <= cpu_write_data;
        r_req.is_wr <= cpu_write_enable;
      end
      // Faulted reads return zero alongside the fault pulse; writes never touch read data.
      if (w_accept && w_fault && !cpu_write_enable) r_rdata <= 32'd0;
      else if (r_state == ST_CAPTURE)               r_rdata <= mem_read_data;
    end
  end

  assign w_done           = (r_state == ST_RESP) || (r_state == ST_FAULT);
  assign cpu_read_data    = r_rdata;
  assign cpu_read_rdy     = w_done && !r_req.is_wr;
  assign cpu_write_rdy    = w_done && r_req.is_wr;
  assign cpu_fault        = (r_state == ST_FAULT);
  assign mem_read_enable  = (r_state == ST_ISSUE) && !r_req.is_wr;
  assign mem_write_enable = (r_state == ST_ISSUE) && r_req.is_wr;
  assign mem_address      = {2'b00, r_req.waddr};
  assign mem_byte_enable  = r_req.be;
  assign mem_write_data   = r_req.wdata;
endmodule

// File: tb/tb_dmem_bridge.sv
// Three bridges (WAIT_STATES 0/1/3), each with its own ssram model, checked against a word-level model.
module tb_dmem_bridge;
  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   c_addr [ND];
  logic [ND-1:0] c_re, c_we;
  logic [3:0]    c_be   [ND];
  logic [31:0]   c_wd   [ND];
  logic [31:0]   c_rdata[ND];
  logic [ND-1:0] c_rrdy, c_wrdy, c_flt;
  logic [31:0]   m_addr [ND];
  logic [ND-1:0] m_re, m_we;
  logic [3:0]    m_be   [ND];
  logic [31:0]   m_wd   [ND];
  logic [ND-1:0] bd_we;
  logic [9:0]    bd_a;
  logic [31:0]   bd_d;

  int total = 0;
  int bad   = 0;
  bit [31:0]   ref_mem [ND][1024];
  logic [31:0] ref_rd  [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    bit   [31:0] mem [1024];
    logic [31:0] rdq;
    dmem_bridge #(.WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3)), .ADDR_WORDS(1024)) u_dut (
      .clk(clk), .rst(rst),
      .cpu_address(c_addr[g]), .cpu_read_enable(c_re[g]), .cpu_write_enable(c_we[g]),
      .cpu_byte_enable(c_be[g]), .cpu_write_data(c_wd[g]), .cpu_read_data(c_rdata[g]),
      .cpu_read_rdy(c_rrdy[g]), .cpu_write_rdy(c_wrdy[g]), .cpu_fault(c_flt[g]),
      .mem_address(m_addr[g]), .mem_read_enable(m_re[g]), .mem_write_enable(m_we[g]),
      .mem_byte_enable(m_be[g]), .mem_write_data(m_wd[g]), .mem_read_data(rdq)
    );
    always @(posedge clk) begin
      if (bd_we[g]) mem[bd_a] <= bd_d;
      else if (m_we[g])
        for (int b = 0; b < 4; b++)
          if (m_be[g][b]) mem[m_addr[g][9:0]][8*b +: 8] <= m_wd[g][8*b +: 8];
      rdq <= m_re[g] ? mem[m_addr[g][9:0]] : 32'hBAD0_BAD0;
    end
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic bit m_fault(input logic [31:0] a, input bit rd, input bit wr);
    return (rd && wr) || (a % 4 != 0) || (a / 4 >= 1024);
  endfunction

  function automatic int m_lat(input int d, input logic [31:0] a, input bit rd, input bit wr);
    if (m_fault(a, rd, wr)) return 1;
    return wr ? ws_of(d) + 2 : ws_of(d) + 3;
  endfunction

  // Read data the CPU should see once this request completes.
  function automatic logic [31:0] m_rdata(input int d, input logic [31:0] a, input bit rd, input bit wr);
    if (wr) return ref_rd[d];
    if (m_fault(a, rd, wr)) return 32'd0;
    return ref_mem[d][a / 4];
  endfunction

  task automatic model_apply(input int d, input logic [31:0] a, input bit rd, input bit wr,
                             input logic [3:0] be, input logic [31:0] wd);
    ref_rd[d] = m_rdata(d, a, rd, wr);
    if (m_fault(a, rd, wr) || !wr) return;
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[d][a / 4][8*b +: 8] = wd[8*b +: 8];
  endtask

  task automatic bd_write(input int d, input int a, input logic [31:0] v);
    bd_a = 10'(a); bd_d = v; bd_we[d] = 1'b1;
    @(posedge clk); #1;
    bd_we[d] = 1'b0;
    ref_mem[d][a] = v;
  endtask

  // Drives one request (called 1 unit after an edge, bridge idle) and records what the bridge did.
  task automatic run_txn(input int d, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd, input bit hold,
                         output int lat, output int nstb, output int stb_cyc,
                         output logic [31:0] stb_addr, output bit stb_wr,
                         output bit got_r, output bit got_w, output bit got_f,
                         output logic [31:0] rdata, output bit after);
    c_addr[d] = a; c_re[d] = rd; c_we[d] = wr; c_be[d] = be; c_wd[d] = wd;
    lat = -1; nstb = 0; stb_cyc = -1; stb_addr = '0; stb_wr = 0;
    got_r = 0; got_w = 0; got_f = 0; rdata = '0; after = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (m_re[d] | m_we[d]) begin
        nstb++; stb_cyc = k; stb_addr = m_addr[d]; stb_wr = m_we[d];
      end
      if (c_rrdy[d] | c_wrdy[d] | c_flt[d]) begin
        lat = k; got_r = c_rrdy[d]; got_w = c_wrdy[d]; got_f = c_flt[d]; rdata = c_rdata[d];
        break;
      end
    end
    if (!hold) begin c_re[d] = 1'b0; c_we[d] = 1'b0; end
    @(posedge clk); #1;
    after = c_rrdy[d] | c_wrdy[d] | c_flt[d] | m_re[d] | m_we[d];
    model_apply(d, a, rd, wr, be, wd);
  endtask

  int lat, nstb, scyc;
  logic [31:0] saddr, rdata;
  bit swr, gr, gw, gf, aft;

  task automatic test_reset();
    for (int d = 0; d < ND; d++) begin
      total++;
      if ({c_rrdy[d], c_wrdy[d], c_flt[d], m_re[d], m_we[d]} !== 5'b0 || c_rdata[d] !== 32'd0) begin
        bad++;
        $display("FAIL reset_outputs d=%0d got rdy/flt/stb=%b rdata=%h exp 0/0", d,
                 {c_rrdy[d], c_wrdy[d], c_flt[d], m_re[d], m_we[d]}, c_rdata[d]);
      end
    end
  endtask

  task automatic test_read_ws1();
    run_txn(1, 1, 0, 32'h10, 4'hF, 32'h0, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (lat !== 4) begin bad++; $display("FAIL rd_ws1_lat got=%0d exp=4", lat); end
    total++; if (nstb !== 1 || scyc !== 2 || swr !== 0) begin bad++;
      $display("FAIL rd_ws1_strobe got n=%0d cyc=%0d wr=%0d exp 1/2/0", nstb, scyc, swr); end
    total++; if (saddr !== 32'd4) begin bad++; $display("FAIL rd_ws1_addr got=%h exp=4", saddr); end
    total++; if (rdata !== 32'hDEADBEEF || !gr || gw || gf) begin bad++;
      $display("FAIL rd_ws1_data got=%h r/w/f=%0d%0d%0d exp DEADBEEF 100", rdata, gr, gw, gf); end
    total++; if (aft !== 0) begin bad++; $display("FAIL rd_ws1_rdy_width got=%0d exp=0", aft); end
  endtask

  task automatic test_write_ws0();
    logic [31:0] prev;
    prev = ref_rd[0];
    run_txn(0, 0, 1, 32'h8, 4'b0011, 32'h12345678, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (lat !== 2 || !gw || gr || gf) begin bad++;
      $display("FAIL wr_ws0_lat got=%0d r/w/f=%0d%0d%0d exp 2 010", lat, gr, gw, gf); end
    total++; if (nstb !== 1 || scyc !== 1 || swr !== 1 || saddr !== 32'd2) begin bad++;
      $display("FAIL wr_ws0_strobe got n=%0d cyc=%0d wr=%0d a=%h exp 1/1/1/2", nstb, scyc, swr, saddr); end
    total++; if (rdata !== prev) begin bad++; $display("FAIL wr_keeps_rdata got=%h exp=%h", rdata, prev); end
    run_txn(0, 1, 0, 32'h8, 4'hF, 32'h0, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (rdata[15:0] !== 16'h5678 || rdata !== ref_rd[0] || lat !== 3) begin bad++;
      $display("FAIL wr_ws0_readback got=%h lat=%0d exp=%h lat=3", rdata, lat, ref_rd[0]); end
  endtask

  task automatic test_fault_misalign();
    run_txn(1, 1, 0, 32'h6, 4'hF, 32'h0, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (lat !== 1 || !gf || !gr || gw) begin bad++;
      $display("FAIL misalign_resp got lat=%0d r/w/f=%0d%0d%0d exp 1 101", lat, gr, gw, gf); end
    total++; if (nstb !== 0) begin bad++; $display("FAIL misalign_strobe got=%0d exp=0", nstb); end
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL misalign_rdata got=%h exp=0", rdata); end
  endtask

  task automatic test_fault_range();
    run_txn(1, 0, 1, 32'h1000, 4'hF, 32'hCAFEF00D, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (lat !== 1 || !gf || !gw || gr || nstb !== 0) begin bad++;
      $display("FAIL range_resp got lat=%0d r/w/f=%0d%0d%0d n=%0d exp 1 011 0", lat, gr, gw, gf, nstb); end
    run_txn(1, 0, 0 | 1'b0, 32'h0, 4'h0, 32'h0, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    run_txn(1, 1, 0, 32'h0, 4'hF, 32'h0, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (rdata !== ref_mem[1][0]) begin bad++;
      $display("FAIL range_mem_unchanged got=%h exp=%h", rdata, ref_mem[1][0]); end
    run_txn(0, 1, 1, 32'h4, 4'hF, 32'h55AA55AA, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (lat !== 1 || !gf || !gw || gr || nstb !== 0) begin bad++;
      $display("FAIL both_en_resp got lat=%0d r/w/f=%0d%0d%0d n=%0d exp 1 011 0", lat, gr, gw, gf, nstb); end
  endtask

  task automatic test_back_to_back();
    int lat1;
    bit aft1;
    run_txn(1, 1, 0, 32'hC, 4'hF, 32'h0, 1, lat1, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft1);
    run_txn(1, 1, 0, 32'hC, 4'hF, 32'h0, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (lat1 !== 4 || lat !== 4) begin bad++;
      $display("FAIL b2b_rd_lat got=%0d,%0d exp=4,4", lat1, lat); end
    total++; if (aft1 !== 0 || aft !== 0 || rdata !== ref_mem[1][3]) begin bad++;
      $display("FAIL b2b_rd_width got after=%0d%0d data=%h exp 00 %h", aft1, aft, rdata, ref_mem[1][3]); end
    run_txn(0, 0, 1, 32'h14, 4'hF, 32'h0BADCAFE, 1, lat1, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft1);
    run_txn(0, 0, 1, 32'h14, 4'hF, 32'h0BADCAFE, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (lat1 !== 2 || lat !== 2 || aft1 !== 0) begin bad++;
      $display("FAIL b2b_wr got lat=%0d,%0d after=%0d exp 2,2 0", lat1, lat, aft1); end
  endtask

  task automatic test_random();
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 25; n++) begin
        logic [31:0] a, wd, er;
        logic [3:0] be;
        bit rd, wr, ef;
        int sel, el;
        sel = $urandom_range(0, 9);
        if (sel <= 6)      a = 32'($urandom_range(0, 31) * 4);
        else if (sel == 7) a = 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
        else if (sel == 8) a = 32'(($urandom_range(0, 100) + 1024) * 4);
        else               a = $urandom();
        sel = $urandom_range(0, 6);
        rd = (sel <= 2) || (sel == 6);
        wr = (sel >= 3);
        be = 4'($urandom()); wd = $urandom();
        ef = m_fault(a, rd, wr); el = m_lat(d, a, rd, wr); er = m_rdata(d, a, rd, wr);
        run_txn(d, rd, wr, a, be, wd, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
        total++;
        if (lat !== el || gf !== ef || gw !== wr || gr !== !wr || aft !== 0) begin bad++;
          $display("FAIL rnd_resp d=%0d a=%h rd=%0d wr=%0d got lat=%0d r/w/f=%0d%0d%0d aft=%0d exp lat=%0d f=%0d",
                   d, a, rd, wr, lat, gr, gw, gf, aft, el, ef); end
        total++;
        if (nstb !== (ef ? 0 : 1) || (!ef && (saddr !== a / 4 || swr !== wr))) begin bad++;
          $display("FAIL rnd_strobe d=%0d a=%h got n=%0d addr=%h wr=%0d exp n=%0d addr=%h",
                   d, a, nstb, saddr, swr, ef ? 0 : 1, a / 4); end
        total++;
        if (rdata !== er) begin bad++;
          $display("FAIL rnd_rdata d=%0d a=%h got=%h exp=%h", d, a, rdata, er); end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    run_txn(2, 1, 0, 32'h1C, 4'hF, 32'h0, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    c_addr[2] = 32'h14; c_re[2] = 1'b1; c_we[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if ({c_rrdy[2], c_wrdy[2], c_flt[2], m_re[2], m_we[2]} !== 5'b0 || c_rdata[2] !== 32'd0) begin bad++;
      $display("FAIL rst_async got rdy/flt/stb=%b rdata=%h exp 0/0",
               {c_rrdy[2], c_wrdy[2], c_flt[2], m_re[2], m_we[2]}, c_rdata[2]); end
    c_re[2] = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      seen |= c_rrdy[2] | c_wrdy[2] | c_flt[2] | m_re[2] | m_we[2];
    end
    for (int d = 0; d < ND; d++) ref_rd[d] = 32'd0;
    rst = 1'b1;
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_abandon got activity=%0d exp=0", seen); end
    run_txn(2, 1, 0, 32'h14, 4'hF, 32'h0, 0, lat, nstb, scyc, saddr, swr, gr, gw, gf, rdata, aft);
    total++; if (lat !== 6 || rdata !== ref_mem[2][5] || !gr) begin bad++;
      $display("FAIL rst_then_read got lat=%0d data=%h exp lat=6 data=%h", lat, rdata, ref_mem[2][5]); end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      c_addr[d] = '0; c_be[d] = '0; c_wd[d] = '0; ref_rd[d] = '0;
    end
    c_re = '0; c_we = '0; bd_we = '0; bd_a = '0; bd_d = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    for (int d = 0; d < ND; d++)
      for (int w = 0; w < 32; w++) bd_write(d, w, $urandom());
    bd_write(1, 4, 32'hDEADBEEF);
    bd_write(2, 7, 32'hA5A50001);
    rst = 1'b1;
    test_read_ws1();
    test_write_ws0();
    test_fault_misalign();
    test_fault_range();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule
